// File: rtl/spi_rx_deser.sv
// spi_rx_deser
//   SPI slave-side receiver. spi_sclk, spi_cs and spi_di are oversampled in the clk
//   domain and LSB-first (or MSB-first) words are rebuilt from them. Completed words
//   are offered on a valid/ready stream, together with overflow and framing status.
//
//   Build option: define SPI_RX_FIFO_EN for a FIFO_DEPTH-entry output FIFO. When it is
//   left undefined, the output storage is a single holding register.
//
// Ports
//   clk        in   system clock, at least 4x the SCLK frequency
//   rst_n      in   asynchronous active-low reset
//   spi_sclk   in   serial clock, asynchronous, idle low
//   spi_cs     in   chip select, active low, asynchronous
//   spi_di     in   serial data, asynchronous, ignored while spi_cs is high
//   m_data     out  head word of the output storage
//   m_valid    out  m_data holds a word
//   m_ready    in   downstream accepts; a word is popped when m_valid && m_ready
//   ovf        out  sticky: a word was dropped because the storage was full
//   ovf_clr    in   synchronous clear of ovf (a new overflow in the same cycle wins)
//   frame_err  out  one-cycle pulse: CS rose while a partial word was in progress
//   busy       out  high while the receiver is in SHIFT
module spi_rx_deser #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int LSB_FIRST  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_sclk,
  input  logic              spi_cs,
  input  logic              spi_di,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              ovf,
  input  logic              ovf_clr,
  output logic              frame_err,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  // Fail elaboration on a FIFO depth that the pointer scheme cannot handle.
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("spi_rx_deser: FIFO_DEPTH must be a power of 2 and >= 2");
  end

  // ---------------------------------------------------------------------------
  // Input synchronizers. CS resets high so that reset never looks like a frame
  // start.
  // ---------------------------------------------------------------------------
  logic sclk_s1, sclk_sync, sclk_d;
  logic cs_s1, cs_sync;
  logic di_s1, di_sync;
  logic sclk_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_s1   <= 1'b0;
      sclk_sync <= 1'b0;
      sclk_d    <= 1'b0;
      cs_s1     <= 1'b1;
      cs_sync   <= 1'b1;
      di_s1     <= 1'b0;
      di_sync   <= 1'b0;
    end else begin
      sclk_s1   <= spi_sclk;
      sclk_sync <= sclk_s1;
      sclk_d    <= sclk_sync;
      cs_s1     <= spi_cs;
      cs_sync   <= cs_s1;
      di_s1     <= spi_di;
      di_sync   <= di_s1;
    end
  end

  assign sclk_rise = sclk_sync & ~sclk_d;

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_next;
  logic              push;

  always_comb begin
    shreg_next = shreg;
    if (LSB_FIRST != 0) begin
      // New bits enter at the top so that the first bit ends up in bit 0.
      shreg_next = {di_sync, shreg[DATA_W-1:1]};
    end else begin
      shreg_next = {shreg[DATA_W-2:0], di_sync};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!cs_sync) begin
            state   <= ST_SHIFT;
            bit_cnt <= '0;
            shreg   <= '0;
          end
        end
        ST_SHIFT: begin
          if (cs_sync) begin
            state     <= ST_IDLE;
            frame_err <= (bit_cnt != '0);
            bit_cnt   <= '0;
          end else if (sclk_rise) begin
            shreg <= shreg_next;
            if (bit_cnt == CNT_W'(DATA_W - 1)) begin
              state   <= ST_LOAD;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        ST_LOAD: begin
          // shreg is consumed by the storage during this cycle.
          state <= cs_sync ? ST_IDLE : ST_SHIFT;
          shreg <= '0;
        end
        default: begin
          state   <= ST_IDLE;
          bit_cnt <= '0;
        end
      endcase
    end
  end

  assign push = (state == ST_LOAD);
  assign busy = (state == ST_SHIFT);

  // ---------------------------------------------------------------------------
  // Output storage
  // ---------------------------------------------------------------------------
  logic pop;
  logic ovf_set;

  assign pop = m_valid && m_ready;

`ifdef SPI_RX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;
  logic              full, empty;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      // When full, a coincident pop frees the very slot being written.
      if (push && (!full || pop)) begin
        mem[wr_ptr[AW-1:0]] <= shreg;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

  assign m_data  = mem[rd_ptr[AW-1:0]];
  assign m_valid = !empty;
  assign ovf_set = push && full && !pop;
`else
  logic [DATA_W-1:0] hold;
  logic              hold_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold     <= '0;
      hold_vld <= 1'b0;
    end else begin
      if (push && (!hold_vld || pop)) begin
        // Push with a coincident pop replaces the word and keeps valid high.
        hold     <= shreg;
        hold_vld <= 1'b1;
      end else if (pop) begin
        hold_vld <= 1'b0;
      end
    end
  end

  assign m_data  = hold;
  assign m_valid = hold_vld;
  assign ovf_set = push && hold_vld && !pop;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (ovf_set) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_rx_deser.sv
// tb_spi_rx_deser
//   Self-checking bench for spi_rx_deser. An SPI master drives whole or short frames;
//   a reference model keeps the queue of words the receiver must deliver and the
//   expected overflow / framing status. A monitor collects delivered words.
module tb_spi_rx_deser;

`ifdef SPI_RX_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic       clk;
  logic       rst_n;
  logic       spi_sclk;
  logic       spi_cs;
  logic       spi_di;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       ovf;
  logic       ovf_clr;
  logic       frame_err;
  logic       busy;

  spi_rx_deser #(
    .DATA_W     (8),
    .FIFO_DEPTH (4),
    .LSB_FIRST  (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .spi_sclk  (spi_sclk),
    .spi_cs    (spi_cs),
    .spi_di    (spi_di),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] tx_q[$];
  int         fe_cycles = 0;
  int         fe_exp    = 0;
  logic       exp_ovf   = 1'b0;
  bit         stalled   = 1'b0;
  int         held      = 0;

  task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_vec++;
    if (got_v !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
    end
  endtask

  // Transfers complete on the posedge following this sample point.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && m_valid && m_ready) got_q.push_back(m_data);
      if (frame_err) fe_cycles++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: words the receiver must keep given the current backpressure.
  function automatic void model_byte(input logic [7:0] b);
    if (!stalled) begin
      exp_q.push_back(b);
    end else if (held < CAP) begin
      exp_q.push_back(b);
      held++;
    end else begin
      exp_ovf = 1'b1;
    end
  endfunction

  task automatic idle_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] d, input int nbits, input bit chk_busy);
    for (int i = 0; i < nbits; i++) begin
      spi_di = d[i];
      idle_clks(4);
      if (chk_busy) chk("busy_mid_frame", 32'(busy), 1);
      spi_sclk = 1'b1;
      idle_clks(4);
      spi_sclk = 1'b0;
    end
  endtask

  // Sends every byte of tx_q in one CS frame, optionally followed by a short tail.
  task automatic send_frame(input int short_bits, input bit chk_busy);
    spi_cs = 1'b0;
    idle_clks(4);
    foreach (tx_q[i]) begin
      send_bits(tx_q[i], 8, chk_busy);
      model_byte(tx_q[i]);
    end
    if (short_bits > 0) begin
      send_bits(8'($urandom), short_bits, 1'b0);
      fe_exp++;
    end
    idle_clks(4);
    spi_cs = 1'b1;
    idle_clks(10);
    tx_q.delete();
  endtask

  task automatic drain_check(input string tag);
    int n;
    m_ready = 1'b1;
    stalled = 1'b0;
    held    = 0;
    n = 0;
    while (got_q.size() < exp_q.size() && n < 300) begin
      idle_clks(1);
      n++;
    end
    idle_clks(5);
    chk({tag, "_beats"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk({tag, "_data"}, 32'(got_q[i]), 32'(exp_q[i]));
    end
    chk({tag, "_frame_err"}, fe_cycles, fe_exp);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    rst_n    = 1'b0;
    spi_cs   = 1'b1;
    spi_sclk = 1'b0;
    spi_di   = 1'b0;
    m_ready  = 1'b0;
    ovf_clr  = 1'b0;
    idle_clks(5);
    rst_n = 1'b1;
    idle_clks(5);

    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_m_data", 32'(m_data), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_frame_err", 32'(frame_err), 0);
    chk("rst_busy", 32'(busy), 0);

    // Reset in the middle of a byte, then a clean frame.
    spi_cs = 1'b0;
    idle_clks(4);
    send_bits(8'hB1, 3, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_m_valid", 32'(m_valid), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_frame_err", 32'(frame_err), 0);
    spi_cs = 1'b1;
    idle_clks(3);
    rst_n = 1'b1;
    idle_clks(5);
    m_ready = 1'b1;
    tx_q.push_back(8'hB1);
    send_frame(0, 1'b0);
    drain_check("after_reset");

    // Single byte.
    tx_q.push_back(8'hB1);
    send_frame(0, 1'b0);
    drain_check("single");

    // Back-to-back words in one frame.
    tx_q = '{8'h01, 8'hFF, 8'h5A, 8'hA5};
    send_frame(0, 1'b1);
    drain_check("b2b");
    chk("b2b_ovf", 32'(ovf), 0);

    // Overflow under backpressure.
    m_ready = 1'b0;
    stalled = 1'b1;
    held    = 0;
    for (int i = 0; i <= CAP; i++) tx_q.push_back(8'($urandom));
    send_frame(0, 1'b0);
    chk("ovf_set", 32'(ovf), 32'(exp_ovf));
    drain_check("ovf");
    chk("ovf_sticky", 32'(ovf), 1);
    ovf_clr = 1'b1;
    idle_clks(1);
    ovf_clr = 1'b0;
    exp_ovf = 1'b0;
    #1;
    chk("ovf_clr", 32'(ovf), 0);

    // Short frame followed by a good one.
    send_frame(5, 1'b0);
    tx_q.push_back(8'h3C);
    send_frame(0, 1'b0);
    drain_check("short");

    // Storage full, push coincident with pop.
    m_ready = 1'b0;
    stalled = 1'b1;
    held    = 0;
    for (int i = 0; i < CAP; i++) tx_q.push_back(8'($urandom));
    send_frame(0, 1'b0);
    begin
      logic [7:0] b;
      b = 8'($urandom);
      spi_cs = 1'b0;
      idle_clks(4);
      send_bits(b, 7, 1'b0);
      spi_di = b[7];
      idle_clks(4);
      spi_sclk = 1'b1;
      idle_clks(3);
      m_ready = 1'b1;
      idle_clks(1);
      m_ready = 1'b0;
      spi_sclk = 1'b0;
      exp_q.push_back(b);
      idle_clks(4);
      spi_cs = 1'b1;
      idle_clks(10);
    end
    chk("fullpop_ovf", 32'(ovf), 0);
    chk("fullpop_m_valid", 32'(m_valid), 1);
    drain_check("fullpop");

    // Randomized frames with optional short tails.
    for (int f = 0; f < 25; f++) begin
      int nb;
      int sb;
      nb = $urandom_range(1, 3);
      for (int i = 0; i < nb; i++) tx_q.push_back(8'($urandom));
      sb = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 7) : 0;
      send_frame(sb, 1'b0);
      drain_check("random");
    end
    chk("random_ovf", 32'(ovf), 32'(exp_ovf));
    chk("end_m_valid", 32'(m_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
